// File: rtl/rmst_fm_tile_loader.sv
// rmst_fm_tile_loader
//
// Read-master controller that fetches one input-feature-map tile (with the
// convolution halo) from external memory into the load FIFO. It issues one
// read burst per row segment. Segments are walked innermost, then rows, then
// channels. Extents are clipped at the feature-map edges. Rows wider than
// MAX_BURST are split into several bursts.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   load_start             start a tile load (sampled only when idle)
//   load_done              one-cycle pulse once the whole tile is transferred
//   busy                   high whenever the controller is not idle
//   tile_base_n/row/col    tile origin (channel, input row, input column)
//   param_raddr            burst byte address, registered
//   param_iolen            burst length in words, registered
//   load_trans_start       one-cycle burst request to the read master
//   load_trans_done        burst completion from the read master
//   load_fifo_almost_full  back-pressure from the load FIFO
//   trans_cnt              bursts completed in the current tile

module rmst_fm_tile_loader #(
    parameter int unsigned AW        = 12,
    parameter int unsigned CW        = 16,
    parameter int unsigned DW        = 32,
    parameter int unsigned N         = 32,
    parameter int unsigned R         = 64,
    parameter int unsigned C         = 32,
    parameter int unsigned Tn        = 16,
    parameter int unsigned Tr        = 16,
    parameter int unsigned Tc        = 16,
    parameter int unsigned S         = 1,
    parameter int unsigned K         = 3,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned FM_BASE   = 65536
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    output logic          load_done,
    output logic          busy,
    input  logic [CW-1:0] tile_base_n,
    input  logic [CW-1:0] tile_base_row,
    input  logic [CW-1:0] tile_base_col,
    output logic [DW-1:0] param_raddr,
    output logic [AW-1:0] param_iolen,
    output logic          load_trans_start,
    input  logic          load_trans_done,
    input  logic          load_fifo_almost_full,
    output logic [CW-1:0] trans_cnt
);

    // Input tile size including the halo.
    localparam int unsigned IR = (Tr - 1) * S + K;
    localparam int unsigned IC = (Tc - 1) * S + K;

    localparam logic [CW-1:0] DimN      = CW'(N);
    localparam logic [CW-1:0] DimR      = CW'(R);
    localparam logic [CW-1:0] DimC      = CW'(C);
    localparam logic [CW-1:0] TileN     = CW'(Tn);
    localparam logic [CW-1:0] TileR     = CW'(IR);
    localparam logic [CW-1:0] TileC     = CW'(IC);
    localparam logic [CW-1:0] MaxBurstC = CW'(MAX_BURST);
    localparam logic [CW-1:0] CntOne    = CW'(1);
    localparam logic [DW-1:0] DimRW     = DW'(R);
    localparam logic [DW-1:0] DimCW     = DW'(C);
    localparam logic [DW-1:0] FmBaseW   = DW'(FM_BASE);
    localparam logic [CW:0]   SegRound  = (CW + 1)'(MAX_BURST - 1);
    localparam logic [CW:0]   SegDiv    = (CW + 1)'(MAX_BURST);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StWait,
        StIssue,
        StTrans,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [CW-1:0] bn_q, bn_d, br_q, br_d, bc_q, bc_d;
    logic [CW-1:0] en_q, en_d, er_q, er_d, ec_q, ec_d, nseg_q, nseg_d;
    logic [CW-1:0] seg_q, seg_d, row_q, row_d, ch_q, ch_d;
    logic [CW-1:0] trans_cnt_q, trans_cnt_d;
    logic [DW-1:0] raddr_q, raddr_d;
    logic [AW-1:0] iolen_q, iolen_d;
    logic          af_q;

    // min(tile, dim - base), or 0 when the base lies outside the map.
    function automatic logic [CW-1:0] extent(input logic [CW-1:0] base,
                                             input logic [CW-1:0] dim,
                                             input logic [CW-1:0] tile);
        logic [CW-1:0] rem;
        if (base >= dim) begin
            return '0;
        end
        rem = dim - base;
        return (rem < tile) ? rem : tile;
    endfunction

    logic [CW-1:0] en_c, er_c, ec_c, nseg_c;
    logic [CW:0]   seg_round;
    logic          zero_extent;

    always_comb begin
        en_c        = extent(bn_q, DimN, TileN);
        er_c        = extent(br_q, DimR, TileR);
        ec_c        = extent(bc_q, DimC, TileC);
        seg_round   = {1'b0, ec_c} + SegRound;
        nseg_c      = CW'(seg_round / SegDiv);
        zero_extent = (en_c == '0) || (er_c == '0) || (ec_c == '0);
    end

    // Burst parameters for the current (channel, row, segment) position.
    logic [CW-1:0] seg_off;
    logic          last_seg, last_row, last_ch;
    logic [DW-1:0] chan_w, row_w, word_w;
    logic [AW-1:0] iolen_w;

    always_comb begin
        seg_off  = seg_q * MaxBurstC;
        last_seg = (seg_q == nseg_q - CntOne);
        last_row = (row_q == er_q - CntOne);
        last_ch  = (ch_q == en_q - CntOne);
        chan_w   = DW'(bn_q) + DW'(ch_q);
        row_w    = DW'(br_q) + DW'(row_q);
        word_w   = FmBaseW + (chan_w * DimRW + row_w) * DimCW + DW'(bc_q) + DW'(seg_off);
        iolen_w  = last_seg ? AW'(ec_q - seg_off) : AW'(MAX_BURST);
    end

    always_comb begin
        state_d     = state_q;
        bn_d        = bn_q;
        br_d        = br_q;
        bc_d        = bc_q;
        en_d        = en_q;
        er_d        = er_q;
        ec_d        = ec_q;
        nseg_d      = nseg_q;
        seg_d       = seg_q;
        row_d       = row_q;
        ch_d        = ch_q;
        trans_cnt_d = trans_cnt_q;
        raddr_d     = raddr_q;
        iolen_d     = iolen_q;

        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    bn_d        = tile_base_n;
                    br_d        = tile_base_row;
                    bc_d        = tile_base_col;
                    trans_cnt_d = '0;
                    state_d     = StSetup;
                end
            end
            StSetup: begin
                en_d    = en_c;
                er_d    = er_c;
                ec_d    = ec_c;
                nseg_d  = nseg_c;
                seg_d   = '0;
                row_d   = '0;
                ch_d    = '0;
                state_d = zero_extent ? StDone : StWait;
            end
            StWait: begin
                if (!af_q) begin
                    raddr_d = word_w << 2;
                    iolen_d = iolen_w;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StTrans;
            end
            StTrans: begin
                if (load_trans_done) begin
                    trans_cnt_d = trans_cnt_q + CntOne;
                    if (last_seg) begin
                        seg_d = '0;
                        if (last_row) begin
                            row_d = '0;
                            ch_d  = ch_q + CntOne;
                        end else begin
                            row_d = row_q + CntOne;
                        end
                    end else begin
                        seg_d = seg_q + CntOne;
                    end
                    state_d = (last_seg && last_row && last_ch) ? StDone : StWait;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bn_q        <= '0;
            br_q        <= '0;
            bc_q        <= '0;
            en_q        <= '0;
            er_q        <= '0;
            ec_q        <= '0;
            nseg_q      <= '0;
            seg_q       <= '0;
            row_q       <= '0;
            ch_q        <= '0;
            trans_cnt_q <= '0;
            raddr_q     <= '0;
            iolen_q     <= '0;
            af_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            bn_q        <= bn_d;
            br_q        <= br_d;
            bc_q        <= bc_d;
            en_q        <= en_d;
            er_q        <= er_d;
            ec_q        <= ec_d;
            nseg_q      <= nseg_d;
            seg_q       <= seg_d;
            row_q       <= row_d;
            ch_q        <= ch_d;
            trans_cnt_q <= trans_cnt_d;
            raddr_q     <= raddr_d;
            iolen_q     <= iolen_d;
            // FIFO flag is registered, so WAIT reacts to it one cycle late.
            af_q        <= load_fifo_almost_full;
        end
    end

    assign busy             = (state_q != StIdle);
    assign load_done        = (state_q == StDone);
    assign load_trans_start = (state_q == StIssue);
    assign param_raddr      = raddr_q;
    assign param_iolen      = iolen_q;
    assign trans_cnt        = trans_cnt_q;

endmodule

// File: tb/tb_rmst_fm_tile_loader.sv
module tb_rmst_fm_tile_loader;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic        load_done;
    logic        busy;
    logic [15:0] tile_base_n;
    logic [15:0] tile_base_row;
    logic [15:0] tile_base_col;
    logic [31:0] param_raddr;
    logic [11:0] param_iolen;
    logic        load_trans_start;
    logic        load_trans_done;
    logic        load_fifo_almost_full;
    logic [15:0] trans_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Geometry of the tile currently being loaded (hand-derived per test).
    int g_bn, g_br, g_bc, g_nseg, g_er, g_ec;
    logic [31:0] cap_addr;
    logic [31:0] cap_len;

    rmst_fm_tile_loader dut (
        .clk                   (clk),
        .rst                   (rst),
        .load_start            (load_start),
        .load_done             (load_done),
        .busy                  (busy),
        .tile_base_n           (tile_base_n),
        .tile_base_row         (tile_base_row),
        .tile_base_col         (tile_base_col),
        .param_raddr           (param_raddr),
        .param_iolen           (param_iolen),
        .load_trans_start      (load_trans_start),
        .load_trans_done       (load_trans_done),
        .load_fifo_almost_full (load_fifo_almost_full),
        .trans_cnt             (trans_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Burst idx walks segment fastest, then row, then channel.
    function automatic logic [31:0] exp_addr(input int idx);
        int seg, r, n;
        seg = idx % g_nseg;
        r   = (idx / g_nseg) % g_er;
        n   = idx / (g_nseg * g_er);
        return 32'((65536 + ((g_bn + n) * 64 + g_br + r) * 32 + g_bc + seg * 16) * 4);
    endfunction

    function automatic logic [31:0] exp_len(input int idx);
        if ((idx % g_nseg) == g_nseg - 1) begin
            return 32'(g_ec - (g_nseg - 1) * 16);
        end
        return 32'd16;
    endfunction

    task automatic start_tile(input int bn, input int br, input int bc,
                              input int nseg, input int er, input int ec);
        g_bn = bn; g_br = br; g_bc = bc; g_nseg = nseg; g_er = er; g_ec = ec;
        tile_base_n   = 16'(bn);
        tile_base_row = 16'(br);
        tile_base_col = 16'(bc);
        load_start    = 1'b1;
        @(negedge clk);
        load_start    = 1'b0;
    endtask

    // Wait for a burst request (w0 cycles already elapsed since the reference
    // event), check its latency and parameters, then optionally acknowledge it
    // 5 cycles after the request.
    task automatic do_burst(input int idx, input int w0, input int exp_lat, input bit ack,
                            input bit raise_af);
        int w;
        w = w0;
        while (load_trans_start !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        check($sformatf("start_lat[%0d]", idx), 32'(w), 32'(exp_lat));
        check($sformatf("raddr[%0d]", idx), param_raddr, exp_addr(idx));
        check($sformatf("iolen[%0d]", idx), 32'(param_iolen), exp_len(idx));
        check($sformatf("trans_cnt[%0d]", idx), 32'(trans_cnt), 32'(idx));
        cap_addr = param_raddr;
        cap_len  = 32'(param_iolen);
        @(negedge clk);
        check($sformatf("start_pulse[%0d]", idx), 32'(load_trans_start), 32'd0);
        if (raise_af) load_fifo_almost_full = 1'b1;
        if (ack) begin
            repeat (3) @(negedge clk);
            check($sformatf("raddr_hold[%0d]", idx), param_raddr, cap_addr);
            load_trans_done = 1'b1;
            @(negedge clk);
            load_trans_done = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        load_start = 1'b0;
        tile_base_n = '0;
        tile_base_row = '0;
        tile_base_col = '0;
        load_trans_done = 1'b0;
        load_fifo_almost_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_tstart", 32'(load_trans_start), 32'd0);
        check("rst_raddr", param_raddr, 32'd0);
        check("rst_iolen", 32'(param_iolen), 32'd0);
        check("rst_cnt", 32'(trans_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full tile at origin: en=16, er=18, ec=18 -> 2 segments per row.
        start_tile(0, 0, 0, 2, 18, 18);
        for (int i = 0; i < 576; i++) begin
            do_burst(i, 1, (i == 0) ? 3 : 2, 1'b1, 1'b0);
            if (i == 0) begin
                check("t1_b1_addr", cap_addr, 32'd262144);
                check("t1_b1_len", cap_len, 32'd16);
            end else if (i == 1) begin
                check("t1_b2_addr", cap_addr, 32'd262208);
                check("t1_b2_len", cap_len, 32'd2);
            end else if (i == 2) begin
                check("t1_b3_addr", cap_addr, 32'd262272);
                check("t1_b3_len", cap_len, 32'd16);
            end else if (i < 575) begin
                check("t1_no_early_done", 32'(load_done), 32'd0);
            end
        end
        check("t1_done", 32'(load_done), 32'd1);
        check("t1_cnt", 32'(trans_cnt), 32'd576);
        @(negedge clk);
        check("t1_done_pulse", 32'(load_done), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_cnt_hold", 32'(trans_cnt), 32'd576);
        repeat (2) @(negedge clk);

        // Edge tile: en=16, er=16, ec=16 -> one segment per row.
        start_tile(16, 48, 16, 1, 16, 16);
        for (int i = 0; i < 256; i++) begin
            do_burst(i, 1, (i == 0) ? 3 : 2, 1'b1, 1'b0);
            if (i == 0) check("t2_first_addr", cap_addr, 32'd399424);
            if (i == 255) check("t2_last_len", cap_len, 32'd16);
        end
        check("t2_done", 32'(load_done), 32'd1);
        check("t2_cnt", 32'(trans_cnt), 32'd256);
        repeat (2) @(negedge clk);

        // Out-of-range base row: no bursts, done two cycles after start.
        start_tile(0, 64, 0, 1, 1, 1);
        check("t3_busy", 32'(busy), 32'd1);
        check("t3_done_early", 32'(load_done), 32'd0);
        check("t3_cnt_clear", 32'(trans_cnt), 32'd0);
        @(negedge clk);
        check("t3_done", 32'(load_done), 32'd1);
        check("t3_tstart", 32'(load_trans_start), 32'd0);
        @(negedge clk);
        check("t3_idle", 32'(busy), 32'd0);
        check("t3_tstart2", 32'(load_trans_start), 32'd0);
        check("t3_cnt", 32'(trans_cnt), 32'd0);
        repeat (2) @(negedge clk);

        // Back-pressure held from start; stray start/done while waiting.
        load_fifo_almost_full = 1'b1;
        start_tile(0, 0, 0, 2, 18, 18);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("t4_stall[%0d]", i), 32'(load_trans_start), 32'd0);
            if (i == 3) begin
                tile_base_row = 16'd5;
                load_start = 1'b1;
                load_trans_done = 1'b1;
            end else begin
                load_start = 1'b0;
                load_trans_done = 1'b0;
            end
            @(negedge clk);
        end
        load_fifo_almost_full = 1'b0;
        do_burst(0, 0, 2, 1'b1, 1'b1);
        check("t4_b1_addr", cap_addr, 32'd262144);
        // almost_full raised mid-TRANS: burst 0 completed, burst 1 held off.
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t4_stall2[%0d]", i), 32'(load_trans_start), 32'd0);
            load_start = (i == 2);
            load_trans_done = (i == 4);
            @(negedge clk);
        end
        load_start = 1'b0;
        load_trans_done = 1'b0;
        check("t4_cnt_after_stall", 32'(trans_cnt), 32'd1);
        load_fifo_almost_full = 1'b0;
        do_burst(1, 0, 2, 1'b1, 1'b0);
        check("t4_b2_addr", cap_addr, 32'd262208);
        check("t4_b2_len", cap_len, 32'd2);
        for (int i = 2; i < 99; i++) begin
            do_burst(i, 1, 2, 1'b1, 1'b0);
        end
        // Reset during the 100th burst.
        do_burst(99, 1, 2, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(load_done), 32'd0);
        check("t5_rst_tstart", 32'(load_trans_start), 32'd0);
        check("t5_rst_raddr", param_raddr, 32'd0);
        check("t5_rst_iolen", 32'(param_iolen), 32'd0);
        check("t5_rst_cnt", 32'(trans_cnt), 32'd0);
        rst = 1'b0;
        load_trans_done = 1'b1;
        @(negedge clk);
        load_trans_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_no_reissue[%0d]", i), 32'(load_trans_start), 32'd0);
            @(negedge clk);
        end
        check("t5_still_idle", 32'(busy), 32'd0);
        start_tile(0, 0, 0, 2, 18, 18);
        do_burst(0, 1, 3, 1'b1, 1'b0);
        check("t5_restart_addr", cap_addr, 32'd262144);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
